// File: rtl/button_conditioner_if.sv
// Button/step bundle between the board button pins and the cursor stage.
//   btnU/btnD/btnL/btnR : raw asynchronous push-buttons, active-high
//   stepU/stepD/stepL/stepR : single-cycle step pulses, active-high
// master drives the buttons and receives steps; slave is the conditioner.
interface button_conditioner_if;
    logic btnU;
    logic btnD;
    logic btnL;
    logic btnR;
    logic stepU;
    logic stepD;
    logic stepL;
    logic stepR;

    modport master (
        output btnU, btnD, btnL, btnR,
        input  stepU, stepD, stepL, stepR
    );

    modport slave (
        input  btnU, btnD, btnL, btnR,
        output stepU, stepD, stepL, stepR
    );
endinterface

// File: rtl/button_conditioner.sv
// Conditions four raw push-buttons into rate-limited single-cycle step pulses.
// Each channel is synchronised (2 flops), debounced, edge-detected and
// auto-repeated while held. Channels are fully independent.
// Ports:
//   clk    : system clock, all registers on rising edge
//   rst    : synchronous active-high reset
//   btn_if : slave side of button_conditioner_if (btn* in, step* out, registered)
module button_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned REPEAT_DELAY    = 50_000_000,
    parameter int unsigned REPEAT_PERIOD   = 10_000_000
) (
    input  logic                 clk,
    input  logic                 rst,
    button_conditioner_if.slave  btn_if
);

    localparam int unsigned NCH = 4;
    localparam int unsigned CW  = 27;

    localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] RD_DUE   = CW'(REPEAT_DELAY);
    localparam logic [CW-1:0] RP_LAST  = CW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } state_e;

    // Channel index: 0 = up, 1 = down, 2 = left, 3 = right
    logic [NCH-1:0] btn_raw;
    logic [NCH-1:0] s1_q;
    logic [NCH-1:0] s2_q;
    logic [NCH-1:0] stable_q;
    logic [NCH-1:0] stable_d;
    logic [NCH-1:0] step_q;
    logic [NCH-1:0] step_d;
    logic [CW-1:0]  dcnt_q [NCH];
    logic [CW-1:0]  dcnt_d [NCH];
    logic [CW-1:0]  rcnt_q [NCH];
    logic [CW-1:0]  rcnt_d [NCH];
    state_e         state_q [NCH];
    state_e         state_d [NCH];

    assign btn_raw = {btn_if.btnR, btn_if.btnL, btn_if.btnD, btn_if.btnU};

    // Two-flop synchroniser for the asynchronous pins
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= btn_raw;
            s2_q <= s1_q;
        end
    end

    // Debouncer: accept a new level only after it persists DEBOUNCE_CYCLES edges
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            stable_d[i] = stable_q[i];
            dcnt_d[i]   = dcnt_q[i];
            if (s2_q[i] == stable_q[i]) begin
                dcnt_d[i] = '0;
            end else if (dcnt_q[i] == DB_LAST) begin
                stable_d[i] = s2_q[i];
                dcnt_d[i]   = '0;
            end else begin
                dcnt_d[i] = dcnt_q[i] + CW'(1);
            end
        end
    end

    // Repeat FSM next-state. IDLE is only ever entered with stable low, so
    // stable high while in IDLE is exactly a rising edge. Release is checked
    // first so it always wins over a repeat due in the same cycle.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            state_d[i] = state_q[i];
            rcnt_d[i]  = rcnt_q[i];
            step_d[i]  = 1'b0;
            case (state_q[i])
                ST_IDLE: begin
                    rcnt_d[i] = '0;
                    if (stable_q[i]) begin
                        step_d[i]  = 1'b1;
                        rcnt_d[i]  = CW'(1);
                        state_d[i] = ST_DELAY;
                    end
                end
                ST_DELAY: begin
                    // rcnt holds cycles elapsed since the press pulse
                    if (!stable_q[i]) begin
                        rcnt_d[i]  = '0;
                        state_d[i] = ST_IDLE;
                    end else if (rcnt_q[i] == RD_DUE) begin
                        step_d[i]  = 1'b1;
                        rcnt_d[i]  = '0;
                        state_d[i] = ST_REPEAT;
                    end else begin
                        rcnt_d[i] = rcnt_q[i] + CW'(1);
                    end
                end
                ST_REPEAT: begin
                    if (!stable_q[i]) begin
                        rcnt_d[i]  = '0;
                        state_d[i] = ST_IDLE;
                    end else if (rcnt_q[i] == RP_LAST) begin
                        step_d[i] = 1'b1;
                        rcnt_d[i] = '0;
                    end else begin
                        rcnt_d[i] = rcnt_q[i] + CW'(1);
                    end
                end
                default: begin
                    rcnt_d[i]  = '0;
                    state_d[i] = ST_IDLE;
                end
            endcase
        end
    end

    // Debouncer, FSM and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            stable_q <= '0;
            step_q   <= '0;
            for (int i = 0; i < NCH; i++) begin
                dcnt_q[i]  <= '0;
                rcnt_q[i]  <= '0;
                state_q[i] <= ST_IDLE;
            end
        end else begin
            stable_q <= stable_d;
            step_q   <= step_d;
            for (int i = 0; i < NCH; i++) begin
                dcnt_q[i]  <= dcnt_d[i];
                rcnt_q[i]  <= rcnt_d[i];
                state_q[i] <= state_d[i];
            end
        end
    end

    assign btn_if.stepU = step_q[0];
    assign btn_if.stepD = step_q[1];
    assign btn_if.stepL = step_q[2];
    assign btn_if.stepR = step_q[3];

endmodule
